// File: rtl/apb_i2c_host_arbiter.sv
// APB master front-end for the APB-to-I2C bridge: round-robin arbitration between two
// requesters, two-phase APB transfer, PREADY timeout abort and per-requester responses.
module apb_i2c_host_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             req0_valid,
  input  logic             req0_write,
  input  logic [31:0]      req0_addr,
  input  logic [31:0]      req0_wdata,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [31:0]      rsp0_rdata,
  output logic             rsp0_err,
  input  logic             req1_valid,
  input  logic             req1_write,
  input  logic [31:0]      req1_addr,
  input  logic [31:0]      req1_wdata,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [31:0]      rsp1_rdata,
  output logic             rsp1_err,
  output logic             PSELx,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [31:0]      PADDR,
  output logic [31:0]      PWDATA,
  input  logic [31:0]      PRDATA,
  input  logic             PREADY,
  input  logic             PSLVERR,
  output logic             busy,
  output logic [CNT_W-1:0] timeout_count
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP_ERR} state_t;

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             pwrite_q, pwrite_d;
  logic [31:0]      paddr_q, paddr_d;
  logic [31:0]      pwdata_q, pwdata_d;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       ready_q, ready_d;
  logic [1:0]       ready_dly_q;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_err_q, rsp_err_d;
  logic [31:0]      rsp0_rdata_q, rsp0_rdata_d;
  logic [31:0]      rsp1_rdata_q, rsp1_rdata_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] tcount_q, tcount_d;

  logic [1:0]       eligible;
  logic             sel;
  logic [31:0]      sel_addr;
  logic [8:0]       wait_inc;
  logic             rsp_fire;
  logic             rsp_err;
  logic [31:0]      rsp_rdata;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    wait_d       = wait_q;
    ready_d      = 2'b00;
    rsp_valid_d  = 2'b00;
    rsp_err_d    = 2'b00;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    tcount_d     = tcount_q;
    rsp_fire     = 1'b0;
    rsp_err      = 1'b0;
    rsp_rdata    = '0;

    // A requester that was just accepted may still show valid for one more cycle.
    eligible = {req1_valid & ~ready_dly_q[1], req0_valid & ~ready_dly_q[0]};
    sel      = (eligible == 2'b11) ? ~last_grant_q : eligible[1];
    sel_addr = sel ? req1_addr : req0_addr;
    wait_inc = {1'b0, wait_q} + 9'd1;

    case (state_q)
      IDLE: begin
        if (eligible != 2'b00) begin
          owner_d      = sel;
          last_grant_d = sel;
          ready_d[sel] = 1'b1;
          paddr_d      = sel_addr;
          pwrite_d     = sel ? req1_write : req0_write;
          pwdata_d     = sel ? req1_wdata : req0_wdata;
          if (sel_addr[31:4] == 28'd0 && sel_addr[1:0] == 2'b00) begin
            psel_d  = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = RESP_ERR;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rsp_fire  = 1'b1;
          rsp_err   = PSLVERR;
          rsp_rdata = pwrite_q ? 32'd0 : PRDATA;
          state_d   = IDLE;
        end else if (wait_inc == TIMEOUT_LIM) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rsp_fire  = 1'b1;
          rsp_err   = 1'b1;
          if (tcount_q != '1) begin
            tcount_d = tcount_q + CNT_W'(1);
          end
          state_d   = IDLE;
        end else begin
          wait_d = wait_inc[7:0];
        end
      end
      RESP_ERR: begin
        rsp_fire = 1'b1;
        rsp_err  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rsp_fire) begin
      rsp_valid_d[owner_q] = 1'b1;
      rsp_err_d[owner_q]   = rsp_err;
      if (owner_q) begin
        rsp1_rdata_d = rsp_rdata;
      end else begin
        rsp0_rdata_d = rsp_rdata;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      wait_q       <= '0;
      ready_q      <= 2'b00;
      ready_dly_q  <= 2'b00;
      rsp_valid_q  <= 2'b00;
      rsp_err_q    <= 2'b00;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      busy_q       <= 1'b0;
      tcount_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      wait_q       <= wait_d;
      ready_q      <= ready_d;
      ready_dly_q  <= ready_q;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
      busy_q       <= busy_d;
      tcount_q     <= tcount_d;
    end
  end

  assign req0_ready    = ready_q[0];
  assign req1_ready    = ready_q[1];
  assign rsp0_valid    = rsp_valid_q[0];
  assign rsp1_valid    = rsp_valid_q[1];
  assign rsp0_err      = rsp_err_q[0];
  assign rsp1_err      = rsp_err_q[1];
  assign rsp0_rdata    = rsp0_rdata_q;
  assign rsp1_rdata    = rsp1_rdata_q;
  assign PSELx         = psel_q;
  assign PENABLE       = penable_q;
  assign PWRITE        = pwrite_q;
  assign PADDR         = paddr_q;
  assign PWDATA        = pwdata_q;
  assign busy          = busy_q;
  assign timeout_count = tcount_q;

endmodule

// File: tb/tb_apb_i2c_host_arbiter.sv
// Bench for apb_i2c_host_arbiter: directed and random requests checked cycle by cycle
// against a transaction-timeline reference model.
module tb_apb_i2c_host_arbiter;

  localparam int TO = 16;
  localparam int CW = 8;
  localparam int TCOUNT_MAX = (1 << CW) - 1;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
  logic [31:0]   req0_addr, req0_wdata, rsp0_rdata;
  logic          req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
  logic [31:0]   req1_addr, req1_wdata, rsp1_rdata;
  logic          PSELx, PENABLE, PWRITE, PREADY, PSLVERR, busy;
  logic [31:0]   PADDR, PWDATA, PRDATA;
  logic [CW-1:0] timeout_count;

  apb_i2c_host_arbiter #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy), .timeout_count(timeout_count)
  );

  always #5 PCLK = ~PCLK;

  // w = number of ACCESS edges with PREADY low before the slave answers.
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          w;
  } req_t;

  req_t q0[$];
  req_t q1[$];
  int   glog[$];

  int n_checks = 0;
  int n_errors = 0;

  logic       m_inflight, m_last, m_owner, m_legal;
  req_t       m_cur;
  int         m_t, m_total, m_tcount;
  logic [1:0] e_rdy, e_rdy_old, e_rv;
  logic       e_psel, e_pen, e_busy, e_err;
  logic [31:0] e_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [31:0] a);
    return (a == 32'd0) || (a == 32'd4) || (a == 32'd8) || (a == 32'd12);
  endfunction

  function automatic req_t mk(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic se, input int w);
    req_t r;
    r.write = wr; r.addr = a; r.wdata = wd; r.prdata = rd; r.slverr = se; r.w = w;
    return r;
  endfunction

  function automatic req_t rand_req();
    int sel;
    logic [31:0] a;
    int w;
    sel = $urandom_range(0, 9);
    if (sel < 8) a = 32'(4 * (sel % 4));
    else if (sel == 8) a = 32'h10;
    else a = $urandom;
    w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 3) : $urandom_range(0, 6);
    return mk(1'($urandom_range(0, 1)), a, $urandom, $urandom,
              1'($urandom_range(0, 3) == 0), w);
  endfunction

  task automatic model_reset();
    m_inflight = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_legal = 1'b0;
    m_t = 0; m_total = 0; m_tcount = 0;
    e_rdy = 2'b00; e_rdy_old = 2'b00; e_rv = 2'b00;
    e_psel = 1'b0; e_pen = 1'b0; e_busy = 1'b0; e_err = 1'b0; e_rdata = '0;
  endtask

  // Present requests and slave answers for the next edge, then predict what the DUT shows after it.
  task automatic drive_predict();
    logic c0, c1, g, in_access;
    logic [1:0] nxt_rdy;
    int acc;
    req0_valid = (q0.size() > 0);
    if (q0.size() > 0) begin
      req0_write = q0[0].write; req0_addr = q0[0].addr; req0_wdata = q0[0].wdata;
    end
    req1_valid = (q1.size() > 0);
    if (q1.size() > 0) begin
      req1_write = q1[0].write; req1_addr = q1[0].addr; req1_wdata = q1[0].wdata;
    end

    in_access = m_inflight && m_legal && (m_t >= 1) && (m_t < m_total);
    if (in_access) begin
      PREADY  = (m_t == m_cur.w + 1);
      PRDATA  = m_cur.prdata;
      PSLVERR = m_cur.slverr;
    end else begin
      PREADY  = 1'($urandom_range(0, 1));
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom_range(0, 1));
    end

    nxt_rdy = 2'b00; e_rv = 2'b00;
    e_psel = 1'b0; e_pen = 1'b0; e_busy = 1'b0;
    if (m_inflight) begin
      m_t++;
      if (m_t == m_total) begin
        m_inflight = 1'b0;
        e_rv[m_owner] = 1'b1;
        if (!m_legal || m_cur.w >= TO) begin
          e_err = 1'b1; e_rdata = '0;
          if (m_legal && m_tcount < TCOUNT_MAX) m_tcount++;
        end else begin
          e_err = m_cur.slverr;
          e_rdata = m_cur.write ? 32'd0 : m_cur.prdata;
        end
      end else begin
        e_psel = m_legal; e_pen = m_legal; e_busy = 1'b1;
      end
    end else begin
      c0 = req0_valid && !e_rdy_old[0];
      c1 = req1_valid && !e_rdy_old[1];
      if (c0 || c1) begin
        g = (c0 && c1) ? !m_last : c1;
        m_last = g; m_owner = g;
        m_cur = g ? q1[0] : q0[0];
        m_legal = is_legal(m_cur.addr);
        acc = (m_cur.w + 1 < TO) ? m_cur.w + 1 : TO;
        m_total = m_legal ? acc + 1 : 1;
        m_t = 0; m_inflight = 1'b1;
        nxt_rdy[g] = 1'b1;
        e_psel = m_legal; e_busy = 1'b1;
      end
    end
    e_rdy_old = e_rdy;
    e_rdy = nxt_rdy;
  endtask

  task automatic step(input bit gen);
    @(negedge PCLK);
    check_eq("req0_ready", req0_ready, e_rdy[0]);
    check_eq("req1_ready", req1_ready, e_rdy[1]);
    check_eq("rsp0_valid", rsp0_valid, e_rv[0]);
    check_eq("rsp1_valid", rsp1_valid, e_rv[1]);
    check_eq("PSELx", PSELx, e_psel);
    check_eq("PENABLE", PENABLE, e_pen);
    check_eq("busy", busy, e_busy);
    check_eq("timeout_count", timeout_count, m_tcount);
    if (e_busy) begin
      check_eq("PADDR", PADDR, m_cur.addr);
      check_eq("PWRITE", PWRITE, m_cur.write);
      if (m_cur.write) check_eq("PWDATA", PWDATA, m_cur.wdata);
    end
    if (e_rv[0]) begin
      check_eq("rsp0_err", rsp0_err, e_err);
      check_eq("rsp0_rdata", rsp0_rdata, e_rdata);
    end
    if (e_rv[1]) begin
      check_eq("rsp1_err", rsp1_err, e_err);
      check_eq("rsp1_rdata", rsp1_rdata, e_rdata);
    end
    if (e_rv != 2'b00)
      $display("txn port=%0d write=%0d addr=%h wait=%0d err=%0d rdata=%h tcount=%0d",
               m_owner, m_cur.write, m_cur.addr, m_cur.w, e_err, e_rdata, timeout_count);
    if (req0_ready) glog.push_back(0);
    if (req1_ready) glog.push_back(1);
    if (e_rdy[0]) void'(q0.pop_front());
    if (e_rdy[1]) void'(q1.pop_front());
    if (gen) begin
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rand_req());
      if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rand_req());
    end
    drive_predict();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_inflight) && n < budget) begin
      step(1'b0);
      n++;
    end
    step(1'b0);
    check_eq("drain_pending", 32'(q0.size() + q1.size() + int'(m_inflight)), 0);
  endtask

  task automatic release_reset();
    @(negedge PCLK);
    PRESETn = 1'b1;
    model_reset();
    drive_predict();
  endtask

  initial begin
    PRESETn = 1'b0;
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
    PREADY = 0; PSLVERR = 0; PRDATA = '0;
    model_reset();
    repeat (3) @(negedge PCLK);
    check_eq("rst_PSELx", PSELx, 0);
    check_eq("rst_PENABLE", PENABLE, 0);
    check_eq("rst_PWRITE", PWRITE, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", {req1_ready, req0_ready}, 0);
    check_eq("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check_eq("rst_rsp_err", {rsp1_err, rsp0_err}, 0);
    check_eq("rst_PADDR", PADDR, 0);
    check_eq("rst_PWDATA", PWDATA, 0);
    check_eq("rst_rsp0_rdata", rsp0_rdata, 0);
    check_eq("rst_rsp1_rdata", rsp1_rdata, 0);
    check_eq("rst_tcount", timeout_count, 0);
    release_reset();

    // Both requesters continuously valid: grants must alternate starting with 0.
    glog.delete();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(mk(1'b1, 32'(4 * i), 32'h100 + 32'(i), '0, 1'b0, 0));
      q1.push_back(mk(1'b0, 32'(8 + 4 * i), '0, 32'h200 + 32'(i), 1'b0, 0));
    end
    run_idle(200);
    check_eq("order_len", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) check_eq("order", glog[i], i % 2);

    q0.push_back(mk(1'b1, 32'h0, 32'h0000_00A5, $urandom, 1'b0, 0));
    run_idle(100);
    q1.push_back(mk(1'b0, 32'h4, $urandom, 32'hA5A5_0001, 1'b0, 3));
    run_idle(100);
    q1.push_back(mk(1'b1, 32'h10, 32'h1234_5678, $urandom, 1'b0, 0));
    run_idle(100);
    q0.push_back(mk(1'b0, 32'h4, '0, 32'hDEAD_BEEF, 1'b1, 1));
    run_idle(100);
    q0.push_back(mk(1'b1, 32'h8, 32'h5555_AAAA, '0, 1'b0, 1000));
    run_idle(100);
    check_eq("tcount_first", timeout_count, 1);
    for (int i = 0; i < 299; i++) q0.push_back(mk(1'b1, 32'h8, $urandom, '0, 1'b0, 1000));
    run_idle(8000);
    check_eq("tcount_sat", timeout_count, TCOUNT_MAX);

    for (int i = 0; i < 1500; i++) step(1'b1);
    run_idle(2000);

    // Reset in the middle of an ACCESS phase.
    q1.push_back(mk(1'b0, 32'hC, '0, 32'h1111_2222, 1'b0, 10));
    for (int i = 0; i < 40 && !(m_inflight && m_t == 3); i++) step(1'b0);
    check_eq("pre_rst_penable", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    check_eq("async_rst_PSELx", PSELx, 0);
    check_eq("async_rst_PENABLE", PENABLE, 0);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_tcount", timeout_count, 0);
    q0.delete(); q1.delete();
    model_reset();
    req0_valid = 0; req1_valid = 0;
    repeat (2) begin
      @(negedge PCLK);
      check_eq("rst_hold_rsp", {rsp1_valid, rsp0_valid}, 0);
      check_eq("rst_hold_psel", PSELx, 0);
    end
    glog.delete();
    q0.push_back(mk(1'b0, 32'h0, '0, 32'h0BAD_F00D, 1'b0, 2));
    q1.push_back(mk(1'b1, 32'h4, 32'hCAFE_0001, '0, 1'b0, 0));
    release_reset();
    run_idle(100);
    check_eq("post_rst_grants", glog.size(), 2);
    if (glog.size() > 0) check_eq("post_rst_first", glog[0], 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
